// File: rtl/inv_barrel_shifter.sv
// rtl/inv_barrel_shifter.sv - pipelined inverse cyclic shifter for QC-LDPC circulants
// out[i] = in[(i - shift) mod Z], or all zeros for a null circulant; one vector per cycle.
module inv_barrel_shifter #(
   parameter int BITS = 8,
   parameter int Z    = 7,
   parameter int SW   = $clog2(Z)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SW-1:0]          shift,
   input  logic                   zero,
   input  logic signed [BITS-1:0] in  [Z-1:0],
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [BITS-1:0] out [Z-1:0]
);

   logic [SW-1:0] v_vec;
   logic [SW-1:0] ld;

   // A stage may load when it or any stage after it has room, or the sink drains.
   for (genvar k = 0; k < SW; k++) begin : g_ld
      assign ld[k] = out_ready | ~(&v_vec[SW-1:k]);
   end

   assign in_ready = ld[0];

   for (genvar k = 0; k < SW; k++) begin : g_stage
      logic signed [BITS-1:0] src_d [Z-1:0];
      logic signed [BITS-1:0] rot_d [Z-1:0];
      logic [SW-1:0]          src_s;
      logic                   src_z;
      logic                   src_v;
      logic signed [BITS-1:0] dq [Z-1:0];
      logic [SW-1:0]          sq;
      logic                   zq;
      logic                   vq;

      if (k == 0) begin : g_src
         // Null circulants are cleared on entry; zeros stay zeros under rotation.
         for (genvar i = 0; i < Z; i++) begin : g_clr
            assign src_d[i] = zero ? '0 : in[i];
         end
         assign src_s = shift;
         assign src_z = zero;
         assign src_v = in_valid;
      end else begin : g_src
         assign src_d = g_stage[k-1].dq;
         assign src_s = g_stage[k-1].sq;
         assign src_z = g_stage[k-1].zq;
         assign src_v = g_stage[k-1].vq;
      end

      for (genvar i = 0; i < Z; i++) begin : g_rot
         localparam int J = (i + Z - ((1 << k) % Z)) % Z;
         assign rot_d[i] = src_s[k] ? src_d[J] : src_d[i];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vq <= 1'b0;
            zq <= 1'b0;
            sq <= '0;
            dq <= '{default: '0};
         end else if (ld[k]) begin
            vq <= src_v;
            zq <= src_z;
            sq <= src_s;
            dq <= rot_d;
         end
      end

      assign v_vec[k] = vq;
   end

   assign out       = g_stage[SW-1].dq;
   assign out_valid = g_stage[SW-1].vq;

   logic unused_tail;
   assign unused_tail = ^{g_stage[SW-1].sq, g_stage[SW-1].zq};

endmodule

// File: tb/tb_inv_barrel_shifter.sv
// tb/tb_inv_barrel_shifter.sv - scoreboard bench for inv_barrel_shifter
module tb_inv_barrel_shifter;

   localparam int BITS = 8;
   localparam int Z    = 7;
   localparam int SW   = $clog2(Z);

   typedef logic [Z*BITS-1:0] flat_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [SW-1:0]          shift;
   logic                   zero;
   logic signed [BITS-1:0] din  [Z-1:0];
   logic                   out_valid;
   logic                   out_ready;
   logic signed [BITS-1:0] dout [Z-1:0];

   flat_t in_flat;
   flat_t out_flat;

   for (genvar i = 0; i < Z; i++) begin : g_pack
      assign din[i] = in_flat[i*BITS +: BITS];
      assign out_flat[i*BITS +: BITS] = dout[i];
   end

   inv_barrel_shifter #(.BITS(BITS), .Z(Z), .SW(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .shift     (shift),
      .zero      (zero),
      .in        (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    rmode = 0;
   int    lo = 0;
   int    hi = 0;
   bit    lat_chk = 0;
   bit    stalled_prev = 0;
   bit    saw_stall = 0;
   bit    saw_both = 0;
   flat_t prev_out;
   flat_t exp_pending;
   flat_t exp_q [$];
   int    acc_q [$];
   int    e_basic [Z] = '{4, 5, 6, 7, 1, 2, 3};
   int    e_neg   [Z] = '{-7, -1, -2, -3, -4, -5, -6};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic flat_t vec_of(input int a [Z]);
      flat_t r = '0;
      for (int i = 0; i < Z; i++) r[i*BITS +: BITS] = BITS'(a[i]);
      return r;
   endfunction

   function automatic flat_t ramp(input int base, input int step);
      flat_t r = '0;
      for (int i = 0; i < Z; i++) r[i*BITS +: BITS] = BITS'(base + step * i);
      return r;
   endfunction

   function automatic flat_t inv_model(input flat_t v, input int s, input bit z);
      flat_t r = '0;
      if (!z)
         for (int i = 0; i < Z; i++) r[i*BITS +: BITS] = v[((i - (s % Z) + Z) % Z)*BITS +: BITS];
      return r;
   endfunction

   function automatic flat_t fwd_model(input flat_t v, input int s);
      flat_t r = '0;
      for (int i = 0; i < Z; i++) r[i*BITS +: BITS] = v[((i + s) % Z)*BITS +: BITS];
      return r;
   endfunction

   function automatic flat_t rand_vec();
      flat_t r = '0;
      for (int i = 0; i < Z; i++) r[i*BITS +: BITS] = BITS'($urandom);
      return r;
   endfunction

   always @(negedge clk) begin
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         2:       out_ready = !(cyc >= lo && cyc <= hi);
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor samples one time unit before each rising edge.
   always begin
      @(negedge clk);
      #4;
      if (rst_n) begin
         check("in_ready", in_ready, !(exp_q.size() == SW && !out_ready));
         if (!in_ready) saw_stall = 1;
         if (stalled_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_flat, prev_out);
         end
         if (out_valid && out_ready && in_valid && in_ready) saw_both = 1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               flat_t e;
               int    a;
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("out_data", out_flat, e);
               if (lat_chk) check("latency", cyc - a, SW);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_pending);
            acc_q.push_back(cyc);
         end
         stalled_prev = out_valid && !out_ready;
         prev_out = out_flat;
      end else begin
         stalled_prev = 0;
      end
   end

   task automatic send(input flat_t v, input int s, input bit z, input flat_t e);
      int n;
      in_flat = v;
      shift = SW'(s);
      zero = z;
      exp_pending = e;
      in_valid = 1'b1;
      n = 0;
      while (1) begin
         #4;
         if (in_ready) begin
            @(negedge clk);
            break;
         end
         @(negedge clk);
         n++;
         if (n > 50) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      flat_t v;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_flat = '0;
      shift = '0;
      zero = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out_flat, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      lat_chk = 1;
      send(ramp(1, 1), 4, 0, vec_of(e_basic));
      idle(6);

      for (int s = 0; s < Z; s++) send(fwd_model(ramp(1, 1), s), s, 0, ramp(1, 1));
      idle(6);

      send(ramp(1, 1), 7, 0, ramp(1, 1));
      send(ramp(-1, -1), 3, 1, '0);
      send(ramp(-1, -1), 1, 0, vec_of(e_neg));
      idle(6);

      lat_chk = 0;
      lo = cyc + 4;
      hi = cyc + 8;
      rmode = 2;
      for (int n = 0; n < 10; n++) begin
         v = ramp(n, 10);
         send(v, n % Z, 0, inv_model(v, n % Z, 0));
      end
      idle(12);
      check("saw_stall", saw_stall, 1);

      rmode = 1;
      for (int n = 0; n < 8; n++) begin
         v = rand_vec();
         send(v, n, 0, inv_model(v, n, 0));
         idle(1);
      end
      for (int n = 0; n < 8; n++) begin
         v = rand_vec();
         send(v, (n * 3) % 8, 0, inv_model(v, (n * 3) % 8, 0));
      end
      idle(12);
      check("saw_both", saw_both, 1);
      rmode = 0;
      idle(2);

      rmode = 3;
      idle(1);
      for (int n = 0; n < 3; n++) begin
         v = rand_vec();
         send(v, n + 2, 0, inv_model(v, n + 2, 0));
      end
      #1;
      check("full_in_ready", in_ready, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out", out_flat, 0);
      check("midrst_in_ready", in_ready, 1);
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      rmode = 0;
      @(negedge clk);
      lat_chk = 1;
      send(ramp(11, 3), 5, 0, inv_model(ramp(11, 3), 5, 0));
      idle(6);

      check("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_barrel_shifter.md
Name: inv_barrel_shifter

Overview:
- Pipelined inverse cyclic shifter for the QC-LDPC datapath. It undoes the rotation applied by barrel_shifter.
- Check-node results for one Z-sized circulant are rotated back by the same shift value, so the messages return to variable-node order before write-back.
- One full Z-word vector enters per cycle under valid/ready flow control.
- Supports null (all-zero) circulants.

Parameters:
- BITS, 8, width of each signed message word.
- Z, 7, lifting size: number of words per vector.
- SW, $clog2(Z), shift-field width. Also the number of pipeline stages.

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  the input vector, shift and zero inputs are valid this cycle.
- in_ready  output  1  the block accepts input this cycle.
- shift  input  SW  rotation amount; values >= Z act as shift mod Z.
- zero  input  1  null circulant: output vector is forced to all zeros.
- in  input  Z x BITS signed  unpacked array in[Z-1:0].
- out_valid  output  1  out holds a valid vector.
- out_ready  input  1  downstream accepts out this cycle.
- out  output  Z x BITS signed  unpacked array out[Z-1:0].

Behaviour:
- Function:
  - Forward convention (barrel_shifter): fwd[i] = in[(i+s) mod Z].
  - This block computes out[i] = in[(i - shift) mod Z].
  - Chaining barrel_shifter then inv_barrel_shifter with the same s returns the original vector.
  - If zero=1, every out[i] = 0 regardless of in and shift.
- Structure: SW register stages, k = 0..SW-1.
  - Stage k rotates by (2^k mod Z) when bit k of the carried shift is 1; otherwise it passes the data through.
  - Because the stage rotations add modulo Z, any shift in 0..2^SW-1 resolves to shift mod Z.
  - Each stage carries data, remaining shift bits, the zero flag and a valid bit.
  - The zero flag may clear data at stage 0 or at the last stage. The output is identical either way.
- Latency: exactly SW cycles from an accepted input (in_valid & in_ready) to out_valid, provided there is no backpressure. For Z=7 this is 3 cycles.
- Throughput: one vector per cycle while out_ready=1.
- Flow control:
  - Stage k loads when its valid bit is 0 or stage k+1 is loading. For the last stage, the condition is valid=0 or out_ready=1.
  - in_ready = stage-0 load enable. It is combinational from out_ready through the stage valid bits, with no combinational path from in_valid.
  - A stage that is not loading holds its data, shift, zero and valid unchanged.
  - out and out_valid are driven directly from the last stage registers.
  - out must remain stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - When a vector leaves and a new one enters in the same cycle, both happen; there is no bubble.
  - in_valid=0 inserts a bubble (valid=0). Bubbles collapse under backpressure.
- Capacity: at most SW vectors in flight. in_ready=0 only when all stages are valid and out_ready=0.
- Reset (rst_n=0, at any time including mid-transfer):
  - All valid bits clear immediately, asynchronously, so out_valid=0 and in-flight vectors are discarded.
  - out data resets to 0; carried shift and zero reset to 0.
  - in_ready=1 during and after reset.
- Arithmetic: no width growth. Words are moved, never added; sign is preserved.
- Z is not required to be a power of two. Index arithmetic is modulo Z and resolved at elaboration.

Test Plan:
- Basic rotation, Z=7, BITS=8:
  - Stimulus: in[i]=i+1 (in[0]=1..in[6]=7), shift=4, out_ready=1.
  - Required: exactly 3 cycles later, out[0..6]=4,5,6,7,1,2,3 with out_valid=1 for one cycle.
- Round trip:
  - Stimulus: the same vector through barrel_shifter with shift 4, then into this block with shift=4.
  - Required: out[i]=i+1. Repeat for shift 0..6; all must match.
- Shift ≥ Z and null circulant:
  - shift=7 → out equals in, identity.
  - zero=1 with in[i]=-(i+1) → all out[i]=0.
  - Negative words with zero=0, shift=1 → out[0]=-7, out[1]=-1, signs intact.
- Backpressure:
  - Stimulus: stream 10 vectors back-to-back (in[0]=n, shift=n mod 7); hold out_ready=0 for cycles 4–8.
  - Required: in_ready=0 once 3 vectors are held. out is stable while stalled. All 10 emerge in order with no loss or duplication.
- Bubbles plus concurrency:
  - Stimulus: alternating in_valid 1/0 with out_ready toggling every cycle.
  - Required: output sequence equals input sequence. A simultaneous accept and emit causes no bubble or loss.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously (between clock edges) with 3 vectors in flight.
  - Required: out_valid=0 and out=0 immediately. After release, the first new input appears 3 cycles after acceptance with correct data.
